io_device_port: RTL and testbench
=================================

Name: io_device_port

Overview:
- One physical I/O device slot (slots 0–3) on the device side of the processor's I/O controller.
- Input half: debounces a confirm button, captures a 32-bit switch word, and drives the slot's dev_in word and enter_in raise/lower handshake.
- Output half: answers the slot's enter_out request, latches the dev_out word into a display register, and drives the done_out raise/lower handshake.
- Four instances at top level, one per slot.

Parameters:
DATA_W, 32, width of one device word
DEBOUNCE_CYCLES, 16, stable cycles required before a button level change is accepted (≥2)
ENTER_HOLD, 2, cycles enter_in stays high per accepted press (≥2)
SETTLE_CYCLES, 1, cycles after enter_out rise before dev_out_word is latched (≥1)
DONE_HOLD, 2, cycles done_out stays high (≥2)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
sw  in  DATA_W  raw switch word (asynchronous)
btn  in  1  raw confirm button, active-high (asynchronous)
dev_in_word  out  DATA_W  word presented to the controller's dev_in slice
enter_in  out  1  input-ready handshake to controller
dev_out_word  in  DATA_W  controller's dev_out slice for this slot
enter_out  in  1  controller's output request for this slot (level)
done_out  out  1  output-accepted handshake to controller
display_value  out  DATA_W  last word written by the processor
display_valid  out  1  high once any word has been written

Behaviour:
- Reset: sampled only on posedge clk with rst_n=0. All outputs are 0, all FSMs go to IDLE, and the debounce counter and sync flops clear. Reset mid-handshake drops enter_in or done_out the next edge with no completion.
- btn synchronisation: two-flop synchroniser.
- Debouncer:
  - A counter increments while the synced level differs from the accepted level and resets to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the accepted level flips.
  - A press event is a one-cycle pulse on an accepted 0→1 flip.
- Input FSM:
  - IN_IDLE: on press event, capture sw (two-flop synced) into dev_in_word, set enter_in=1, and go to IN_ASSERT.
  - IN_ASSERT: hold enter_in for exactly ENTER_HOLD cycles, then enter_in=0 and go to IN_RELEASE.
  - IN_RELEASE: wait for accepted level 0, then go to IN_IDLE. A held button never produces a second event.
  - dev_in_word changes only on capture and stays stable at all other times, so the controller may sample it after enter_in falls.
  - Press events outside IN_IDLE are ignored.
- Output FSM:
  - OUT_IDLE: on enter_out=1, go to OUT_SETTLE.
  - OUT_SETTLE: count SETTLE_CYCLES. The controller writes dev_out one edge after entering its wait state, so on the final settle cycle latch dev_out_word into display_value, set display_valid=1, set done_out=1, and go to OUT_DONE.
  - OUT_DONE: hold done_out for DONE_HOLD cycles, then done_out=0 and go to OUT_RELEASE. Do not wait for enter_out to fall, or the handshake deadlocks.
  - OUT_RELEASE: wait for enter_out=0, then go to OUT_IDLE. This prevents one long request from writing twice.
  - If enter_out drops during OUT_SETTLE, abort to OUT_IDLE with no latch and no done_out.
- Input and output FSMs are independent. A simultaneous press and enter_out are both serviced in the same cycles.
- Counters are sized $clog2(max param)+1. No wrap-around is reachable, since counters saturate at their compare value.

Decomposition:
- Shared package io_dev_pkg:
  - IN_IDLE/IN_ASSERT/IN_RELEASE encodings (2 bits)
  - OUT_IDLE/OUT_SETTLE/OUT_DONE/OUT_RELEASE encodings (2 bits)
  - default timing constants
- One natural sub-module: button_debouncer (synchroniser, counter, accepted level, press pulse), parameterised by DEBOUNCE_CYCLES.

Test Plan:
- Reset: drive rst_n=0 for 3 cycles with btn=1 and enter_out=1 → all outputs 0. Release reset with btn=1 held → no enter_in, since the accepted level stays 0 until debounced. Outputs stay 0 while both inputs hold.
- Clean press: sw=32'hDEADBEEF, btn high 40 cycles → enter_in high exactly 2 cycles, starting 2+16 cycles after btn rise (±1). dev_in_word=DEADBEEF and stays so after btn release.
- Bounce: btn toggles every 5 cycles for 60 cycles, then stays high → exactly one enter_in pulse. A second press after 20 cycles low produces a second pulse with the new sw value.
- Output write: enter_out rises, and dev_out_word=32'h00000042 from the next cycle → display_value=42 and display_valid=1 one cycle after the rise. done_out is high 2 cycles then low while enter_out is still high. No second done_out until enter_out falls and rises again.
- Aborted request: enter_out high 1 cycle only → display_value unchanged, done_out never asserted.
- Concurrency plus mid-op reset: a press and an enter_out land on the same cycle → both handshakes complete. Repeat with rst_n=0 during OUT_DONE → done_out is 0 next edge, and display_value and display_valid clear.

Source files
------------

// File: rtl/io_dev_pkg.sv
// io_dev_pkg
// Shared definitions for the I/O device slot logic.
//   in_state_t  : input-half handshake states (enter_in side)
//   out_state_t : output-half handshake states (done_out side)
//   DEF_*       : default timing constants for one device slot
//   cnt_width   : width of a counter that must reach the larger of two limits
package io_dev_pkg;

    typedef enum logic [1:0] {
        IN_IDLE    = 2'd0,
        IN_ASSERT  = 2'd1,
        IN_RELEASE = 2'd2
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE    = 2'd0,
        OUT_SETTLE  = 2'd1,
        OUT_DONE    = 2'd2,
        OUT_RELEASE = 2'd3
    } out_state_t;

    localparam int DEF_DATA_W          = 32;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_ENTER_HOLD      = 2;
    localparam int DEF_SETTLE_CYCLES   = 1;
    localparam int DEF_DONE_HOLD       = 2;

    // One spare bit above $clog2 so the compare value always fits.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer
// Synchronises a raw push button and accepts a level change only after it
// has been stable for DEBOUNCE_CYCLES cycles.
//   clk, rst_n : clock and synchronous active-low reset
//   btn        : raw asynchronous button, active-high
//   level      : accepted (debounced) button level
//   press      : one-cycle pulse when the accepted level flips 0 -> 1
import io_dev_pkg::*;

module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES, DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser for the raw button.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Count consecutive cycles of disagreement with the accepted level; any
    // agreement restarts the count, so bounces never accumulate.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync2;
                press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_device_port.sv
// io_device_port
// Device side of one I/O controller slot.
//   clk, rst_n    : clock and synchronous active-low reset
//   sw            : raw switch word, captured on a debounced button press
//   btn           : raw confirm button
//   dev_in_word   : captured switch word offered to the controller
//   enter_in      : input-ready handshake, high ENTER_HOLD cycles per press
//   dev_out_word  : word written by the controller for this slot
//   enter_out     : controller output request (level)
//   done_out      : output-accepted handshake, high DONE_HOLD cycles
//   display_value : last word written by the processor
//   display_valid : high once any word has been written
import io_dev_pkg::*;

module io_device_port #(
    parameter int DATA_W          = DEF_DATA_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int ENTER_HOLD      = DEF_ENTER_HOLD,
    parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int DONE_HOLD       = DEF_DONE_HOLD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw,
    input  logic              btn,
    output logic [DATA_W-1:0] dev_in_word,
    output logic              enter_in,
    input  logic [DATA_W-1:0] dev_out_word,
    input  logic              enter_out,
    output logic              done_out,
    output logic [DATA_W-1:0] display_value,
    output logic              display_valid
);

    localparam int                  IN_W        = cnt_width(ENTER_HOLD, ENTER_HOLD);
    localparam int                  OUT_W       = cnt_width(SETTLE_CYCLES, DONE_HOLD);
    localparam logic [IN_W-1:0]     ENTER_LAST  = IN_W'(ENTER_HOLD - 1);
    localparam logic [OUT_W-1:0]    SETTLE_LAST = OUT_W'(SETTLE_CYCLES - 1);
    localparam logic [OUT_W-1:0]    DONE_LAST   = OUT_W'(DONE_HOLD - 1);

    logic              btn_level;
    logic              btn_press;
    logic [DATA_W-1:0] sw_sync1;
    logic [DATA_W-1:0] sw_sync2;

    in_state_t         in_state;
    in_state_t         in_next;
    logic [IN_W-1:0]   in_cnt;
    logic              capture;

    out_state_t        out_state;
    out_state_t        out_next;
    logic [OUT_W-1:0]  out_cnt;
    logic              latch;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .level (btn_level),
        .press (btn_press)
    );

    // Handshake outputs are decoded from the state registers.
    assign enter_in = (in_state == IN_ASSERT);
    assign done_out = (out_state == OUT_DONE);

    // Switch word synchroniser; the word is only sampled after a debounced
    // press, long after the switches have settled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_sync1 <= '0;
            sw_sync2 <= '0;
        end else begin
            sw_sync1 <= sw;
            sw_sync2 <= sw_sync1;
        end
    end

    // Input FSM next state. Releasing requires the debounced level to drop,
    // so a held button can never raise a second request.
    always_comb begin
        in_next = in_state;
        capture = 1'b0;
        case (in_state)
            IN_IDLE: begin
                if (btn_press) begin
                    in_next = IN_ASSERT;
                    capture = 1'b1;
                end
            end
            IN_ASSERT: begin
                if (in_cnt == ENTER_LAST) begin
                    in_next = IN_RELEASE;
                end
            end
            IN_RELEASE: begin
                if (!btn_level) begin
                    in_next = IN_IDLE;
                end
            end
            default: in_next = IN_IDLE;
        endcase
    end

    // Input state, hold counter and captured word; dev_in_word only moves on
    // a capture so the controller may read it after enter_in falls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_state    <= IN_IDLE;
            in_cnt      <= '0;
            dev_in_word <= '0;
        end else begin
            in_state <= in_next;
            if (in_next != in_state) begin
                in_cnt <= '0;
            end else if (in_state == IN_ASSERT) begin
                in_cnt <= in_cnt + 1'b1;
            end
            if (capture) begin
                dev_in_word <= sw_sync2;
            end
        end
    end

    // Output FSM next state. The controller drives dev_out one edge after it
    // starts waiting, so the word is latched on the last settle cycle. DONE
    // times out on its own; waiting for enter_out to fall there deadlocks.
    always_comb begin
        out_next = out_state;
        latch    = 1'b0;
        case (out_state)
            OUT_IDLE: begin
                if (enter_out) begin
                    out_next = OUT_SETTLE;
                end
            end
            OUT_SETTLE: begin
                if (!enter_out) begin
                    out_next = OUT_IDLE;
                end else if (out_cnt == SETTLE_LAST) begin
                    out_next = OUT_DONE;
                    latch    = 1'b1;
                end
            end
            OUT_DONE: begin
                if (out_cnt == DONE_LAST) begin
                    out_next = OUT_RELEASE;
                end
            end
            OUT_RELEASE: begin
                if (!enter_out) begin
                    out_next = OUT_IDLE;
                end
            end
            default: out_next = OUT_IDLE;
        endcase
    end

    // Output state, shared settle/done counter and display register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_state     <= OUT_IDLE;
            out_cnt       <= '0;
            display_value <= '0;
            display_valid <= 1'b0;
        end else begin
            out_state <= out_next;
            if (out_next != out_state) begin
                out_cnt <= '0;
            end else if (out_state == OUT_SETTLE || out_state == OUT_DONE) begin
                out_cnt <= out_cnt + 1'b1;
            end
            if (latch) begin
                display_value <= dev_out_word;
                display_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_io_device_port.sv
// tb_io_device_port
// Self-checking bench for one I/O device slot. A monitor counts handshake
// pulses and their widths; each scenario task predicts the outcome from the
// slot's rules (press length vs. debounce time, request length vs. settle
// time) and compares against what the monitor and outputs show.
module tb_io_device_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] sw;
    logic        btn;
    logic [31:0] dev_in_word;
    logic        enter_in;
    logic [31:0] dev_out_word;
    logic        enter_out;
    logic        done_out;
    logic [31:0] display_value;
    logic        display_valid;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int ei_pulses = 0, ei_len = 0, ei_rise = 0;
    int do_pulses = 0, do_len = 0;
    logic ei_prev = 1'b0, do_prev = 1'b0;

    // Reference model state
    logic [31:0] exp_dev_in;
    logic [31:0] exp_display;
    logic        exp_valid;

    io_device_port dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sw            (sw),
        .btn           (btn),
        .dev_in_word   (dev_in_word),
        .enter_in      (enter_in),
        .dev_out_word  (dev_out_word),
        .enter_out     (enter_out),
        .done_out      (done_out),
        .display_value (display_value),
        .display_valid (display_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Pulse monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (enter_in && !ei_prev) begin
            ei_pulses++;
            ei_rise = cyc;
            ei_len  = 0;
        end
        if (enter_in) ei_len++;
        ei_prev = enter_in;
        if (done_out && !do_prev) begin
            do_pulses++;
            do_len = 0;
        end
        if (done_out) do_len++;
        do_prev = done_out;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        int bad;
        rst_n = 1'b0; btn = 1'b1; enter_out = 1'b1;
        sw = 32'h1234_5678; dev_out_word = 32'h9999_9999;
        idle(3);
        checks++;
        if ({enter_in, done_out, display_valid} !== 3'b000 || dev_in_word !== 32'h0 || display_value !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got ei=%b do=%b v=%b din=%h disp=%h, want all 0",
                     enter_in, done_out, display_valid, dev_in_word, display_value);
        end
        rst_n = 1'b1; enter_out = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (enter_in !== 1'b0 || done_out !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL reset_held_btn: %0d cycles with a handshake high, want 0", bad);
        end
        btn = 1'b0;
        idle(30);
        exp_dev_in = 32'h0; exp_display = 32'h0; exp_valid = 1'b0;
    endtask

    task automatic test_clean_press;
        int p0, t0;
        p0 = ei_pulses;
        sw = 32'hDEADBEEF;
        idle(3);
        btn = 1'b1; t0 = cyc;
        idle(40);
        btn = 1'b0; sw = $urandom;
        exp_dev_in = 32'hDEADBEEF;
        checks++;
        if (ei_pulses !== p0 + 1 || ei_len !== 2) begin
            errors++;
            $display("[TB] FAIL clean_pulse: got %0d pulses len %0d, want 1 pulse len 2", ei_pulses - p0, ei_len);
        end
        checks++;
        if (ei_rise - t0 < 17 || ei_rise - t0 > 21) begin
            errors++;
            $display("[TB] FAIL clean_latency: got %0d cycles, want 17..21", ei_rise - t0);
        end
        checks++;
        if (dev_in_word !== exp_dev_in) begin
            errors++;
            $display("[TB] FAIL clean_word: got %h want %h", dev_in_word, exp_dev_in);
        end
        idle(40);
        checks++;
        if (dev_in_word !== exp_dev_in || ei_pulses !== p0 + 1) begin
            errors++;
            $display("[TB] FAIL clean_release: got word %h pulses %0d, want %h 1", dev_in_word, ei_pulses - p0, exp_dev_in);
        end
    endtask

    task automatic test_bounce;
        int p0;
        logic [31:0] v;
        p0 = ei_pulses;
        v = $urandom; sw = v;
        idle(3);
        for (int i = 0; i < 12; i++) begin
            btn = (i % 2 == 0);
            idle(5);
        end
        btn = 1'b1;
        idle(40);
        btn = 1'b0;
        exp_dev_in = v;
        checks++;
        if (ei_pulses !== p0 + 1 || dev_in_word !== exp_dev_in) begin
            errors++;
            $display("[TB] FAIL bounce_single: got %0d pulses word %h, want 1 %h", ei_pulses - p0, dev_in_word, exp_dev_in);
        end
        idle(20);
        v = $urandom; sw = v;
        idle(2);
        btn = 1'b1;
        idle(40);
        btn = 1'b0;
        exp_dev_in = v;
        idle(40);
        checks++;
        if (ei_pulses !== p0 + 2 || dev_in_word !== exp_dev_in || ei_len !== 2) begin
            errors++;
            $display("[TB] FAIL bounce_second: got %0d pulses word %h len %0d, want 2 %h 2",
                     ei_pulses - p0, dev_in_word, ei_len, exp_dev_in);
        end
    endtask

    task automatic test_random_presses;
        int p0, h;
        logic long_press;
        logic [31:0] v;
        for (int k = 0; k < 6; k++) begin
            p0 = ei_pulses;
            long_press = $urandom_range(0, 1);
            h = long_press ? $urandom_range(25, 45) : $urandom_range(2, 10);
            v = $urandom; sw = v;
            idle(3);
            btn = 1'b1;
            idle(h);
            btn = 1'b0;
            idle(40);
            if (long_press) exp_dev_in = v;
            checks++;
            if (ei_pulses !== p0 + (long_press ? 1 : 0) || dev_in_word !== exp_dev_in) begin
                errors++;
                $display("[TB] FAIL rand_press_%0d: width %0d got %0d pulses word %h, want %0d %h",
                         k, h, ei_pulses - p0, dev_in_word, long_press ? 1 : 0, exp_dev_in);
            end
        end
    endtask

    task automatic test_output_write;
        int d0, bad;
        d0 = do_pulses;
        enter_out = 1'b1;
        @(negedge clk);
        dev_out_word = 32'h0000_0042;
        @(negedge clk);
        exp_display = 32'h42; exp_valid = 1'b1;
        checks++;
        if (display_value !== exp_display || display_valid !== exp_valid) begin
            errors++;
            $display("[TB] FAIL write_latch: got %h v=%b, want %h v=1", display_value, display_valid, exp_display);
        end
        idle(3);
        checks++;
        if (done_out !== 1'b0 || do_pulses !== d0 + 1 || do_len !== 2) begin
            errors++;
            $display("[TB] FAIL write_done: got done=%b pulses %0d len %0d, want 0 1 2", done_out, do_pulses - d0, do_len);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_out !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || do_pulses !== d0 + 1) begin
            errors++;
            $display("[TB] FAIL write_no_repeat: got %0d extra done cycles, want 0", bad);
        end
        enter_out = 1'b0;
        idle(3);
    endtask

    task automatic test_abort;
        int d0;
        d0 = do_pulses;
        dev_out_word = $urandom;
        enter_out = 1'b1;
        @(negedge clk);
        enter_out = 1'b0;
        idle(6);
        checks++;
        if (display_value !== exp_display || display_valid !== exp_valid || do_pulses !== d0) begin
            errors++;
            $display("[TB] FAIL abort: got %h v=%b done pulses %0d, want %h v=%b 0",
                     display_value, display_valid, do_pulses - d0, exp_display, exp_valid);
        end
    endtask

    task automatic test_random_writes;
        int d0, len;
        logic [31:0] v;
        for (int k = 0; k < 8; k++) begin
            d0 = do_pulses;
            len = $urandom_range(1, 8);
            v = $urandom;
            dev_out_word = v;
            enter_out = 1'b1;
            idle(len);
            enter_out = 1'b0;
            idle($urandom_range(5, 8));
            if (len >= 2) begin
                exp_display = v;
                exp_valid = 1'b1;
            end
            checks++;
            if (display_value !== exp_display || display_valid !== exp_valid ||
                do_pulses !== d0 + (len >= 2 ? 1 : 0)) begin
                errors++;
                $display("[TB] FAIL rand_write_%0d: len %0d got %h v=%b pulses %0d, want %h v=%b %0d",
                         k, len, display_value, display_valid, do_pulses - d0,
                         exp_display, exp_valid, len >= 2 ? 1 : 0);
            end
        end
    endtask

    task automatic test_concurrent;
        int p0, d0;
        logic [31:0] v, w;
        p0 = ei_pulses; d0 = do_pulses;
        v = $urandom; w = $urandom;
        sw = v; dev_out_word = w;
        idle(3);
        btn = 1'b1; enter_out = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 6) enter_out = 1'b0;
            @(negedge clk);
        end
        btn = 1'b0;
        idle(40);
        exp_dev_in = v; exp_display = w; exp_valid = 1'b1;
        checks++;
        if (ei_pulses !== p0 + 1 || do_pulses !== d0 + 1 || dev_in_word !== exp_dev_in || display_value !== exp_display) begin
            errors++;
            $display("[TB] FAIL concurrent: got ei %0d do %0d din %h disp %h, want 1 1 %h %h",
                     ei_pulses - p0, do_pulses - d0, dev_in_word, display_value, exp_dev_in, exp_display);
        end
        // Reset while done_out is high
        dev_out_word = $urandom;
        enter_out = 1'b1;
        idle(2);
        checks++;
        if (done_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_pre: got done=%b, want 1", done_out);
        end
        rst_n = 1'b0;
        @(negedge clk);
        exp_display = 32'h0; exp_valid = 1'b0; exp_dev_in = 32'h0;
        checks++;
        if (done_out !== 1'b0 || display_valid !== exp_valid || display_value !== exp_display || dev_in_word !== exp_dev_in) begin
            errors++;
            $display("[TB] FAIL midreset: got done=%b v=%b disp %h din %h, want 0 0 0 0",
                     done_out, display_valid, display_value, dev_in_word);
        end
        enter_out = 1'b0;
        rst_n = 1'b1;
        idle(5);
        checks++;
        if (done_out !== 1'b0 || display_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_after: got done=%b v=%b, want 0 0", done_out, display_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0; btn = 1'b0; enter_out = 1'b0;
        sw = 32'h0; dev_out_word = 32'h0;
        exp_dev_in = 32'h0; exp_display = 32'h0; exp_valid = 1'b0;
        @(negedge clk);
        test_reset;
        test_clean_press;
        test_bounce;
        test_random_presses;
        test_output_write;
        test_abort;
        test_random_writes;
        test_concurrent;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
